// File: rtl/bram_scan_reader.sv
// Read-side scanner for a 1-cycle registered-read block RAM: walks START_ADDR..END_ADDR,
// one r_en per word, and presents each captured word on a valid/ready stream.
module bram_scan_reader #(
  parameter int          ADDR_W     = 4,
  parameter int          DATA_W     = 2,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] L_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] L_END   = ADDR_W'(END_ADDR);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state;
  logic              w_r_en;
  logic [ADDR_W-1:0] w_r_addr;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [ADDR_W-1:0] w_out_addr;
  logic              w_busy;
  logic              w_done;

  // Next state and next values of every registered output
  always_comb begin
    w_state     = r_state;
    w_r_en      = 1'b0;
    w_r_addr    = r_addr;
    w_out_valid = out_valid;
    w_out_data  = out_data;
    w_out_addr  = out_addr;
    w_busy      = busy;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_READ;
          w_r_addr = L_START;
          w_r_en   = 1'b1;
          w_busy   = 1'b1;
        end else begin
          w_busy   = 1'b0;
        end
      end
      S_READ: begin
        w_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_out_data  = r_data;
        w_out_addr  = r_addr;
        w_out_valid = 1'b1;
        w_state     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          if (r_addr == L_END) begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            // Modulo-2**ADDR_W increment gives the wrapped scan for free
            w_r_addr = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            w_r_en   = 1'b1;
            w_state  = S_READ;
          end
        end else begin
          w_state = S_HOLD;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state     = S_IDLE;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
      end
    endcase
    // Abort overrides any transfer decided above; start in IDLE is unaffected
    if (abort && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_r_en      = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
    end else begin
      w_state     = w_state;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_en      <= w_r_en;
      r_addr    <= w_r_addr;
      out_valid <= w_out_valid;
      out_data  <= w_out_data;
      out_addr  <= w_out_addr;
      busy      <= w_busy;
      done      <= w_done;
    end
  end

endmodule

// File: tb/tb_bram_scan_reader.sv
// Bench for bram_scan_reader: three instances (full, wrapped, single-word scans), each with a
// 1-cycle registered-read RAM model holding mem[i] = i % 4.
module tb_bram_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] en_v, valid_v, busy_v, done_v;
  logic [3:0] addr_v  [3];
  logic [3:0] oaddr_v [3];
  logic [1:0] odata_v [3];
  logic [1:0] rdata_v [3];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {int addr; int data;} exp_t;
  exp_t q[$];

  typedef struct {
    int sel; int n; int first; int stall_addr; int stall_len; int restart_cyc;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  bram_scan_reader #(.ADDR_W(4), .DATA_W(2), .START_ADDR(0), .END_ADDR(15)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .r_en(en_v[0]), .r_addr(addr_v[0]), .r_data(rdata_v[0]),
    .out_valid(valid_v[0]), .out_ready(out_ready), .out_data(odata_v[0]),
    .out_addr(oaddr_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  bram_scan_reader #(.ADDR_W(4), .DATA_W(2), .START_ADDR(14), .END_ADDR(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
    .r_en(en_v[1]), .r_addr(addr_v[1]), .r_data(rdata_v[1]),
    .out_valid(valid_v[1]), .out_ready(out_ready), .out_data(odata_v[1]),
    .out_addr(oaddr_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  bram_scan_reader #(.ADDR_W(4), .DATA_W(2), .START_ADDR(7), .END_ADDR(7)) dut_single (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
    .r_en(en_v[2]), .r_addr(addr_v[2]), .r_data(rdata_v[2]),
    .out_valid(valid_v[2]), .out_ready(out_ready), .out_data(odata_v[2]),
    .out_addr(oaddr_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // RAM models: registered read of mem[addr] = addr % 4
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_v[i]) rdata_v[i] <= addr_v[i][1:0];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_scan(input vec_t v);
    int cyc, ens, stalls, exp_next, n_left;
    bit finished, prev_xfer, rdy;
    exp_t e;
    @(negedge clk);
    start_v[v.sel] = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < v.n; k++) begin
      e.addr = (v.first + k) % 16;
      e.data = e.addr % 4;
      q.push_back(e);
    end
    cyc = 0; ens = 0; stalls = 0; finished = 0; prev_xfer = 0; exp_next = 0; n_left = v.n;
    while (cyc < 200 && !finished) begin
      @(negedge clk);
      cyc++;
      start_v[v.sel] = (cyc == v.restart_cyc);
      ens += int'(en_v[v.sel]);
      if (prev_xfer) begin
        chk("read_after_xfer_en", int'(en_v[v.sel]), 1);
        chk("read_after_xfer_addr", int'(addr_v[v.sel]), exp_next);
        prev_xfer = 0;
      end
      if (done_v[v.sel]) begin
        finished = 1;
        chk("done_cycle", cyc, 3 * v.n + 1 + v.stall_len);
        chk("busy_at_done", int'(busy_v[v.sel]), 0);
        chk("valid_at_done", int'(valid_v[v.sel]), 0);
      end else begin
        chk("busy_during_scan", int'(busy_v[v.sel]), 1);
      end
      if (valid_v[v.sel]) begin
        rdy = !(int'(oaddr_v[v.sel]) == v.stall_addr && stalls < v.stall_len);
        out_ready = rdy;
        if (!rdy) begin
          stalls++;
          chk("stall_no_ren", int'(en_v[v.sel]), 0);
          chk("stall_addr", int'(oaddr_v[v.sel]), v.stall_addr);
          chk("stall_data", int'(odata_v[v.sel]), v.stall_addr % 4);
        end else if (q.size() == 0) begin
          chk("unexpected_word", int'(oaddr_v[v.sel]), -1);
        end else begin
          e = q.pop_front();
          n_left--;
          chk("out_addr", int'(oaddr_v[v.sel]), e.addr);
          chk("out_data", int'(odata_v[v.sel]), e.data);
          if (n_left > 0) begin
            prev_xfer = 1;
            exp_next = (e.addr + 1) % 16;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    start_v[v.sel] = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", int'(finished), 1);
    chk("r_en_count", ens, v.n);
    chk("words_left", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int found, bad;
    vecs[0] = '{sel: 0, n: 16, first: 0,  stall_addr: -1, stall_len: 0, restart_cyc: -1};
    vecs[1] = '{sel: 0, n: 16, first: 0,  stall_addr: 3,  stall_len: 5, restart_cyc: -1};
    vecs[2] = '{sel: 1, n: 4,  first: 14, stall_addr: -1, stall_len: 0, restart_cyc: -1};
    vecs[3] = '{sel: 2, n: 1,  first: 7,  stall_addr: -1, stall_len: 0, restart_cyc: -1};

    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_outputs", int'({en_v[i], addr_v[i], valid_v[i], odata_v[i], oaddr_v[i],
                                  busy_v[i], done_v[i]}), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_scan(vecs[i]);

    // Start pulsed while busy must not disturb the scan
    run_scan('{sel: 0, n: 16, first: 0, stall_addr: -1, stall_len: 0, restart_cyc: 4});

    // Abort while address 5 is in HOLD, with out_ready high in the same cycle
    @(negedge clk);
    start_v[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (valid_v[0] && oaddr_v[0] == 4'd5) found = 1;
    end
    chk("abort_hold_reached", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(valid_v[0]), 0);
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_ren", int'(en_v[0]), 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bad += int'(done_v[0]) + int'(valid_v[0]) + int'(busy_v[0]) + int'(en_v[0]);
    end
    chk("abort_stays_idle", bad, 0);
    run_scan(vecs[0]);

    // Asynchronous reset mid-CAPTURE of address 6
    @(negedge clk);
    start_v[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (en_v[0] && addr_v[0] == 4'd6) found = 1;
    end
    chk("reset_capture_reached", found, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("midscan_reset_outputs", int'({en_v[0], addr_v[0], valid_v[0], odata_v[0], oaddr_v[0],
                                        busy_v[0], done_v[0]}), 0);
    rst_n = 1'b1;
    run_scan(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
